// File: rtl/pwm_ramp_controller.sv
// Ramps a registered PWM duty value toward a latched target in fixed steps,
// one update every tick_div+1 clocks, with retarget and abort support.
module pwm_ramp_controller #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       target,
    input  logic [7:0]       step,
    input  logic [DIV_W-1:0] tick_div,
    output logic [7:0]       duty_out,
    output logic             busy,
    output logic             done,
    output logic             dir
);

    localparam int unsigned DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic [DUTY_W-1:0]   step_q, step_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic                done_d;
    logic                busy_d;
    logic                dir_d;
    logic [DUTY_W:0]     sum_up;
    logic [DUTY_W:0]     floor_dn;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            target_q <= '0;
            step_q   <= '0;
            duty_q   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            dir      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            target_q <= target_d;
            step_q   <= step_d;
            duty_q   <= duty_d;
            done     <= done_d;
            busy     <= busy_d;
            dir      <= dir_d;
        end
    end

    assign duty_out = duty_q;

    // Next-state and datapath; 9-bit arithmetic keeps the clamp free of wrap
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        target_d = target_q;
        step_d   = step_q;
        duty_d   = duty_q;
        done_d   = 1'b0;
        sum_up   = {1'b0, duty_q} + {1'b0, step_q};
        floor_dn = {1'b0, target_q} + {1'b0, step_q};

        if (abort) begin
            if (state_q != IDLE) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (start) begin
            target_d = target;
            step_d   = (step == '0) ? DUTY_W'(1) : step;
            div_d    = tick_div;
            cnt_d    = '0;
            if (target > duty_q) begin
                state_d = UP;
            end else if (target < duty_q) begin
                state_d = DOWN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (state_q != IDLE) begin
            if (cnt_q == div_q) begin
                cnt_d = '0;
                if (state_q == UP) begin
                    if (sum_up >= {1'b0, target_q}) begin
                        duty_d  = target_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        duty_d = DUTY_W'(sum_up);
                    end
                end else begin
                    if ({1'b0, duty_q} <= floor_dn) begin
                        duty_d  = target_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        duty_d = duty_q - step_q;
                    end
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Status outputs follow the next state so they register alongside it
    always_comb begin
        busy_d = (state_d != IDLE);
        dir_d  = (state_d == UP);
    end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Directed bench for pwm_ramp_controller with hand-computed expected values.
module tb_pwm_ramp_controller;

    localparam int unsigned DIV_W = 16;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [7:0]       target;
    logic [7:0]       step;
    logic [DIV_W-1:0] tick_div;
    logic [7:0]       duty_out;
    logic             busy;
    logic             done;
    logic             dir;

    int errors = 0;
    int checks = 0;

    pwm_ramp_controller #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .target   (target),
        .step     (step),
        .tick_div (tick_div),
        .duty_out (duty_out),
        .busy     (busy),
        .done     (done),
        .dir      (dir)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic go(input logic [7:0] t, input logic [7:0] s, input int d);
        target   = t;
        step     = s;
        tick_div = DIV_W'(d);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0; clk_en = 1'b0; rst_n = 1'b1;
        start = 1'b0; abort = 1'b0; target = '0; step = '0; tick_div = '0;

        // Asynchronous reset with the clock stopped
        #3 rst_n = 1'b0;
        #1;
        check("rst_duty", duty_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dir", dir, 0);
        #4 rst_n = 1'b1;
        clk_en = 1'b1;
        ticks(2);
        check("idle_busy", busy, 0);

        // Ramp up 0 -> 100, step 30, every clock
        go(8'd100, 8'd30, 0);
        check("up_busy0", busy, 1);
        check("up_dir0", dir, 1);
        check("up_duty0", duty_out, 0);
        tick(); check("up_d1", duty_out, 30); check("up_dir1", dir, 1);
        tick(); check("up_d2", duty_out, 60);
        tick(); check("up_d3", duty_out, 90); check("up_done3", done, 0);
        tick(); check("up_d4", duty_out, 100); check("up_done4", done, 1);
        check("up_busy4", busy, 0); check("up_dir4", dir, 0);
        tick(); check("up_done5", done, 0);

        // Ramp down 100 -> 5, step 40, every 4 clocks
        go(8'd5, 8'd40, 3);
        check("dn_dir0", dir, 0); check("dn_busy0", busy, 1);
        ticks(3); check("dn_hold", duty_out, 100);
        tick(); check("dn_d1", duty_out, 60);
        ticks(3); check("dn_hold2", duty_out, 60);
        tick(); check("dn_d2", duty_out, 20); check("dn_done2", done, 0);
        ticks(3); check("dn_done_early", done, 0);
        tick(); check("dn_d3", duty_out, 5); check("dn_done3", done, 1);
        tick(); check("dn_done4", done, 0); check("dn_busy4", busy, 0);

        // Clamp to 250 in one large step, then creep to 255 with step 0
        go(8'd250, 8'd255, 0);
        tick(); check("clamp250", duty_out, 250); check("clamp_done", done, 1);
        go(8'd255, 8'd0, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("creep", duty_out, 250 + i);
            check("creep_done", done, (i == 5) ? 1 : 0);
        end
        ticks(3); check("nowrap", duty_out, 255); check("nowrap_busy", busy, 0);

        // Large down steps clamp exactly at target, including zero
        go(8'd10, 8'd255, 0);
        tick(); check("to10", duty_out, 10);
        go(8'd0, 8'd200, 0);
        tick(); check("to0", duty_out, 0); check("to0_done", done, 1);

        // Retarget mid-ramp
        go(8'd200, 8'd30, 0);
        ticks(3); check("rt_d", duty_out, 90);
        go(8'd50, 8'd30, 0);
        check("rt_done", done, 0); check("rt_dir", dir, 0);
        check("rt_busy", busy, 1); check("rt_duty", duty_out, 90);
        tick(); check("rt_d1", duty_out, 60); check("rt_done1", done, 0);
        tick(); check("rt_d2", duty_out, 50); check("rt_done2", done, 1);

        // Start and abort together: abort wins, duty held
        go(8'd200, 8'd10, 0);
        tick(); check("ab_d", duty_out, 60);
        target = 8'd0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("ab_busy", busy, 0); check("ab_duty", duty_out, 60); check("ab_done", done, 0);
        ticks(3); check("ab_hold", duty_out, 60); check("ab_done2", done, 0);

        // Abort in IDLE is a no-op
        abort = 1'b1; tick(); abort = 1'b0;
        check("ab_idle", duty_out, 60); check("ab_idle_done", done, 0);

        // Start with target equal to current duty
        go(8'd60, 8'd5, 0);
        check("eq_done", done, 1); check("eq_busy", busy, 0);
        tick(); check("eq_done2", done, 0); check("eq_duty", duty_out, 60);

        // Reset mid-ramp at duty 60
        rst_n = 1'b0; #1; rst_n = 1'b1; ticks(1);
        go(8'd200, 8'd30, 0);
        ticks(2); check("mr_d", duty_out, 60);
        #2 rst_n = 1'b0;
        #1;
        check("mr_duty", duty_out, 0); check("mr_busy", busy, 0); check("mr_dir", dir, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_done", done, 0);
            check("mr_stay", duty_out, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the update-interval divider.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request: latch target/step/tick_div, begin ramp.
REQ-005 SHALL have port abort  input  1  one-cycle request: stop ramp, hold current duty.
REQ-006 SHALL have port target  input  8  requested final duty cycle, sampled only on start.
REQ-007 SHALL have port step  input  8  duty increment per update, sampled only on start; 0 treated as 1.
REQ-008 SHALL have port tick_div  input  DIV_W  update interval = tick_div+1 clk cycles, sampled only on start.
REQ-009 SHALL have port duty_out  output  8  current duty cycle, drives the PWM peripheral duty input.
REQ-010 SHALL have port busy  output  1  high while in UP or DOWN.
REQ-011 SHALL have port done  output  1  one-cycle pulse when duty_out reaches latched target.
REQ-012 SHALL have port dir  output  1  1 = ramping up, 0 = down or idle.

Function
REQ-013 SHALL implement states IDLE, UP, DOWN; busy = (state != IDLE), dir = (state == UP).
REQ-014 SHALL, on start in IDLE or busy, latch target_q, step_q (max(step,1)), div_q, clear interval counter, and enter UP if target > duty_out, DOWN if target < duty_out.
REQ-015 SHALL, on start with target == duty_out, stay/return to IDLE and assert done on the next cycle.
REQ-016 SHALL increment interval counter each cycle in UP/DOWN; an update occurs on the edge where counter == div_q, counter then returns to 0.
REQ-017 SHALL make the first duty change at the (div_q+1)-th rising edge after the edge that sampled start; subsequent changes every div_q+1 cycles.
REQ-018 SHALL, on update in UP, compute duty_out+step_q in 9 bits; if result >= target_q then duty_out = target_q, done = 1, state = IDLE; else duty_out += step_q.
REQ-019 SHALL, on update in DOWN, if duty_out <= target_q + step_q (9-bit compare, no underflow) then duty_out = target_q, done = 1, state = IDLE; else duty_out -= step_q.
REQ-020 SHALL never wrap duty_out past 255 or below 0; final value is always exactly target_q.
REQ-021 SHALL, on start while busy, retarget from current duty_out without a done pulse for the abandoned ramp.
REQ-022 SHALL, on abort, go IDLE, hold duty_out, clear counter, no done pulse; abort in IDLE has no effect.
REQ-023 SHALL give abort priority when start and abort are asserted in the same cycle.
REQ-024 SHALL register done, busy, dir, duty_out (no combinational path from inputs to outputs).

Reset
REQ-025 SHALL, while rst_n low, force state IDLE, duty_out 0, counter 0, target_q/step_q/div_q 0, busy 0, done 0, dir 0, independent of clk.
REQ-026 SHALL, on reset mid-ramp, abandon the ramp immediately with no done pulse; operation resumes only on a new start after rst_n high.

Verification
REQ-027 Reset: assert rst_n low mid-cycle with clk stopped -> duty_out 0, busy 0, done 0, dir 0 immediately.
REQ-028 Ramp up: duty 0, start target 100 step 30 tick_div 0 -> duty_out 30,60,90,100 on 4 consecutive edges, done pulse with 100, busy low after, dir 1 during.
REQ-029 Ramp down: duty 100, start target 5 step 40 tick_div 3 -> duty_out 60,20,5 every 4 cycles, done once, dir 0.
REQ-030 Boundaries: duty 250, start target 255 step 0 -> 251..255 then done, no wrap; duty 10, start target 0 step 200 -> 0 in one update.
REQ-031 Retarget/abort: mid-ramp to 200, start target 50 -> switches to DOWN from current duty, no done for first ramp; start+abort same cycle -> IDLE, duty held; start target == duty_out -> done next cycle, busy stays 0.
REQ-032 Reset mid-ramp: rst_n low during UP at duty 60 -> duty_out 0, busy 0, no done after release.
